s3g_cmd_ctrl: RTL and testbench

Command sequencer behind the s3g packet receiver. On each completed packet it decodes the command byte and streams the payload out of the receiver's 256-byte buffer RAM to the motion command consumer over a valid/ready byte stream. It then sends a 4-byte s3g response packet through the UART transmitter. The block is the single owner of the receiver's buffer read port and of the tx byte interface.

---
 rtl/s3g_cmd_ctrl_pkg.sv | 17 +
 rtl/s3g_cmd_ctrl_if.sv | 18 +
 rtl/s3g_resp_tx.sv | 55 +++++
 rtl/s3g_cmd_ctrl.sv | 112 +++++++++++
 tb/tb_s3g_cmd_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/s3g_cmd_ctrl_pkg.sv
// s3g_cmd_ctrl_pkg: response codes, state encodings and the s3g crc8 shared by the command sequencer.
package s3g_cmd_ctrl_pkg;
  localparam logic [7:0] RC_OK      = 8'h81;
  localparam logic [7:0] RC_CRC     = 8'h83;
  localparam logic [7:0] RC_UNSUP   = 8'h85;
  localparam logic [7:0] RC_OVERRUN = 8'h88;
  localparam logic [7:0] START_BYTE = 8'hD5;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RD, S_WAIT, S_PUSH, S_TX} state_t;
  typedef enum logic [1:0] {T_IDLE, T_TX, T_TXW1, T_TXW} tx_state_t;
  // Dallas/iButton crc8 (reflected poly 0x8C), as used by s3g framing
  function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ 8'h8C : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/s3g_cmd_ctrl_if.sv
// s3g_cmd_ctrl_if: receiver, stream, uart-tx and statistics signals of the command sequencer.
interface s3g_cmd_ctrl_if #(parameter int CNT_W = 16);
  logic             packet_done, packet_error, buffer_valid;
  logic [7:0]       payload_len, cmd_code, buffer_addr, buffer_data;
  logic [7:0]       out_data;
  logic             out_valid, out_ready, out_last, out_abort;
  logic [7:0]       tx_data;
  logic             tx_start, tx_busy, busy;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;
  modport slave (
    input  packet_done, packet_error, buffer_valid, payload_len, cmd_code, buffer_data, out_ready, tx_busy,
    output buffer_addr, out_data, out_valid, out_last, out_abort, tx_data, tx_start, busy, pkt_cnt, err_cnt
  );
  modport master (
    output packet_done, packet_error, buffer_valid, payload_len, cmd_code, buffer_data, out_ready, tx_busy,
    input  buffer_addr, out_data, out_valid, out_last, out_abort, tx_data, tx_start, busy, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/s3g_resp_tx.sv
// s3g_resp_tx: serializes the 4-byte s3g response (D5, 01, rc, crc8) onto the uart tx byte port.
module s3g_resp_tx
  import s3g_cmd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rc,
  input  logic       i_start,
  output logic       o_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_busy
);
  tx_state_t  r_state;
  logic [1:0] r_idx;
  logic [7:0] r_rc, r_tx_data, w_byte;
  logic       r_tx_start, r_done;
  assign w_byte = r_idx == 2'd0 ? START_BYTE : r_idx == 2'd1 ? 8'h01 : r_idx == 2'd2 ? r_rc : nextCRC8_D8(r_rc, 8'h00);
  assign o_done = r_done;
  assign o_tx_data = r_tx_data;
  assign o_tx_start = r_tx_start;
  // T_TXW1 skips the cycle before the transmitter raises tx_busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= T_IDLE;
      r_idx <= 2'd0;
      r_rc <= 8'h00;
      r_tx_data <= 8'h00;
      r_tx_start <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        T_IDLE: if (i_start) begin
          r_rc <= i_rc;
          r_idx <= 2'd0;
          r_state <= T_TX;
        end
        T_TX: if (!i_tx_busy) begin
          r_tx_data <= w_byte;
          r_tx_start <= 1'b1;
          r_state <= T_TXW1;
        end
        T_TXW1: r_state <= T_TXW;
        T_TXW: if (!i_tx_busy) begin
          r_idx <= r_idx + 2'd1;
          r_done <= r_idx == 2'd3;
          r_state <= r_idx == 2'd3 ? T_IDLE : T_TX;
        end
        default: r_state <= T_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/s3g_cmd_ctrl.sv
// s3g_cmd_ctrl: decodes completed s3g packets, streams STREAM_CMD payloads from the receiver buffer
// and answers every accepted packet or CRC error with a response packet.
module s3g_cmd_ctrl
  import s3g_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0] STREAM_CMD = 8'h90,
  parameter logic [7:0] NOP_CMD    = 8'h00,
  parameter int         CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  s3g_cmd_ctrl_if.slave  bus
);
  state_t           r_state;
  logic [7:0]       r_cmd, r_len, r_rc, r_addr, r_out_data;
  logic             r_out_valid, r_out_last, r_out_abort, r_start;
  logic [CNT_W-1:0] r_pkt_cnt, r_err_cnt;
  logic             w_hs, w_abort, w_done, w_tx_start;
  logic [7:0]       w_tx_data;
  assign w_hs = r_out_valid && bus.out_ready;
  // a byte accepted in the same cycle buffer_valid falls still counts; the abort hits the next byte
  assign w_abort = !bus.buffer_valid && (r_state inside {S_RD, S_WAIT, S_PUSH}) && !w_hs;
  assign bus.buffer_addr = r_addr;
  assign bus.out_data = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last = r_out_last;
  assign bus.out_abort = r_out_abort;
  assign bus.tx_data = w_tx_data;
  assign bus.tx_start = w_tx_start;
  assign bus.busy = r_state != S_IDLE;
  assign bus.pkt_cnt = r_pkt_cnt;
  assign bus.err_cnt = r_err_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cmd <= 8'h00;
      r_len <= 8'h00;
      r_rc <= 8'h00;
      r_addr <= 8'h00;
      r_out_data <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last <= 1'b0;
      r_out_abort <= 1'b0;
      r_start <= 1'b0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_start <= 1'b0;
      r_out_abort <= 1'b0;
      if (r_state != S_IDLE && (bus.packet_done || bus.packet_error)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (w_abort) begin
        r_out_valid <= 1'b0;
        r_out_abort <= 1'b1;
        r_rc <= RC_OVERRUN;
        r_start <= 1'b1;
        r_state <= S_TX;
      end else begin
        case (r_state)
          S_IDLE: if (bus.packet_done) begin
            r_cmd <= bus.cmd_code;
            r_len <= bus.payload_len;
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            r_state <= S_DECODE;
          end else if (bus.packet_error) begin
            r_rc <= RC_CRC;
            r_err_cnt <= r_err_cnt + CNT_W'(1);
            r_start <= 1'b1;
            r_state <= S_TX;
          end
          S_DECODE: if (r_cmd == STREAM_CMD && r_len >= 8'd2) begin
            r_addr <= 8'd1;
            r_state <= S_RD;
          end else begin
            r_rc <= (r_len != 8'd0 && (r_cmd == NOP_CMD || r_cmd == STREAM_CMD)) ? RC_OK : RC_UNSUP;
            r_start <= 1'b1;
            r_state <= S_TX;
          end
          S_RD: r_state <= S_WAIT;
          S_WAIT: begin
            r_out_data <= bus.buffer_data;
            r_out_last <= r_addr == r_len - 8'd1;
            r_out_valid <= 1'b1;
            r_state <= S_PUSH;
          end
          S_PUSH: if (w_hs) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_rc <= RC_OK;
              r_start <= 1'b1;
              r_state <= S_TX;
            end else begin
              r_addr <= r_addr + 8'd1;
              r_state <= S_RD;
            end
          end
          S_TX: if (w_done) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  s3g_resp_tx u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .i_rc      (r_rc),
    .i_start   (r_start),
    .o_done    (w_done),
    .o_tx_data (w_tx_data),
    .o_tx_start(w_tx_start),
    .i_tx_busy (bus.tx_busy)
  );
endmodule

// File: tb/tb_s3g_cmd_ctrl.sv
// tb_s3g_cmd_ctrl: directed packets against a queue-based model of the stream and response bytes.
module tb_s3g_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  s3g_cmd_ctrl_if bus ();
  s3g_cmd_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, bad = 0;
  logic [8:0] exp_out[$];
  logic [7:0] exp_tx[$];
  logic [7:0] mem[256];
  logic [7:0] tx_last[4];
  int acc_total = 0, tx_total = 0, abort_seen = 0, exp_abort = 0, exp_pkt = 0, exp_err = 0;
  int stall_idx = 0, stall_len = 0, stall_cnt = 0, busy_cnt = 0;
  bit stall_on = 1'b0, hold_busy = 1'b0, stalled = 1'b0;
  logic [8:0] held = '0;

  always #5 clk = ~clk;

  assign bus.tx_busy = hold_busy || busy_cnt != 0;
  always @(posedge clk) begin
    bus.buffer_data <= mem[bus.buffer_addr];
    busy_cnt <= bus.tx_start ? 3 : (busy_cnt != 0 ? busy_cnt - 1 : 0);
  end

  always @(negedge clk) begin
    if (stall_on && bus.out_valid && acc_total == stall_idx && stall_cnt < stall_len) begin
      bus.out_ready = 1'b0;
      stall_cnt++;
    end else bus.out_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  task automatic model_resp(input logic [7:0] rc);
    exp_tx.push_back(8'hD5);
    exp_tx.push_back(8'h01);
    exp_tx.push_back(rc);
    exp_tx.push_back(crc8(rc));
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    #1;
    if (!rst) stalled = 1'b0;
    else begin
      if (bus.out_valid && stalled) chk("hold_stable", {bus.out_last, bus.out_data}, held);
      stalled = bus.out_valid && !bus.out_ready;
      held = {bus.out_last, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        e = exp_out.size() != 0 ? exp_out.pop_front() : 9'h000;
        chk("out_byte", {1'b0, bus.out_last, bus.out_data}, exp_out.size() + 1 > 0 ? {1'b0, e} : 10'h200);
        acc_total++;
      end
      if (bus.tx_start) begin
        chk("tx_after_stream", exp_out.size(), 0);
        if (exp_tx.size() != 0) chk("tx_byte", bus.tx_data, exp_tx.pop_front());
        else chk("tx_unexpected", tx_total, -1);
        tx_last[tx_total % 4] = bus.tx_data;
        tx_total++;
      end
      if (bus.out_abort) begin
        abort_seen++;
        chk("abort_valid_low", bus.out_valid, 0);
      end
    end
  end

  task automatic send(input logic [7:0] cmd, input logic [7:0] len, input bit model);
    mem[0] = cmd;
    @(negedge clk);
    bus.cmd_code = cmd;
    bus.payload_len = len;
    bus.packet_done = 1'b1;
    exp_pkt++;
    if (model) begin
      if (cmd == 8'h90 && len >= 2)
        for (int i = 1; i < int'(len); i++) exp_out.push_back({i == int'(len) - 1, mem[i]});
      model_resp(len != 0 && (cmd == 8'h00 || cmd == 8'h90) ? 8'h81 : 8'h85);
    end
    @(negedge clk);
    bus.packet_done = 1'b0;
  endtask

  task automatic send_err;
    @(negedge clk);
    bus.packet_error = 1'b1;
    exp_err++;
    model_resp(8'h83);
    @(negedge clk);
    bus.packet_error = 1'b0;
  endtask

  task automatic wait_out(input logic [7:0] d);
    int n = 0;
    while (!(bus.out_valid && bus.out_data == d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_timeout", n < 200, 1);
  endtask

  task automatic wait_idle;
    int n = 0;
    repeat (3) @(negedge clk);
    while ((bus.busy || exp_tx.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("idle_timeout", n < 3000, 1);
    chk("out_drained", exp_out.size(), 0);
    chk("pkt_cnt", bus.pkt_cnt, exp_pkt[15:0]);
    chk("err_cnt", bus.err_cnt, exp_err[15:0]);
    chk("abort_cnt", abort_seen, exp_abort);
  endtask

  initial begin
    int t0, n;
    bus.packet_done = 1'b0;
    bus.packet_error = 1'b0;
    bus.buffer_valid = 1'b0;
    bus.payload_len = 8'h00;
    bus.cmd_code = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_abort", bus.out_abort, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_buffer_addr", bus.buffer_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.buffer_valid = 1'b1;

    mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
    send(8'h90, 8'd4, 1'b1);
    wait_idle;
    chk("lit_rc_ok", tx_last[2], 8'h81);
    chk("lit_crc_81", tx_last[3], 8'hD2);

    stall_idx = acc_total + 1; stall_len = 10; stall_cnt = 0; stall_on = 1'b1;
    send(8'h90, 8'd4, 1'b1);
    wait_idle;
    chk("stall_cycles", stall_cnt, 10);
    stall_on = 1'b0;

    send_err;
    wait_idle;
    chk("lit_crc_83", tx_last[3], 8'h6E);

    send(8'h42, 8'd3, 1'b1); wait_idle;
    chk("lit_rc_unsup", tx_last[2], 8'h85);
    send(8'h90, 8'd0, 1'b1); wait_idle;
    send(8'h00, 8'd1, 1'b1); wait_idle;
    send(8'h90, 8'd1, 1'b1); wait_idle;
    mem[1] = 8'hEE;
    send(8'h90, 8'd2, 1'b1); wait_idle;
    send(8'h90, 8'd255, 1'b1); wait_idle;

    mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3; mem[4] = 8'hA4;
    exp_out.push_back({1'b0, 8'hA1});
    model_resp(8'h88);
    exp_abort++;
    stall_idx = acc_total + 1; stall_len = 1000; stall_cnt = 0; stall_on = 1'b1;
    send(8'h90, 8'd5, 1'b0);
    wait_out(8'hA2);
    repeat (2) @(negedge clk);
    bus.buffer_valid = 1'b0;
    wait_idle;
    chk("lit_rc_overrun", tx_last[2], 8'h88);
    bus.buffer_valid = 1'b1;
    stall_on = 1'b0;

    send_err;
    t0 = tx_total; n = 0;
    while (tx_total == t0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_tx_timeout", n < 100, 1);
    hold_busy = 1'b1;
    @(negedge clk);
    bus.cmd_code = 8'h00;
    bus.payload_len = 8'd1;
    bus.packet_done = 1'b1;
    exp_err++;
    @(negedge clk);
    bus.packet_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_while_held", bus.busy, 1);
    chk("no_tx_while_held", tx_total, t0 + 1);
    hold_busy = 1'b0;
    wait_idle;

    stall_idx = acc_total; stall_len = 1000; stall_cnt = 0; stall_on = 1'b1;
    send(8'h90, 8'd5, 1'b0);
    wait_out(8'hA1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_abort", bus.out_abort, 0);
    chk("mid_rst_tx_start", bus.tx_start, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("mid_rst_err_cnt", bus.err_cnt, 0);
    exp_out.delete();
    exp_pkt = 0;
    exp_err = 0;
    stall_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(8'h00, 8'd1, 1'b1);
    wait_idle;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
